// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and helpers for the iterative multiply/divide unit
// Purpose: operation and FSM state encodings plus the counter-width helper.
// Ports: none (package).
package multdiv_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_MUL  = 2'd1,
    OP_DIV  = 2'd2
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to hold any value in 0..value-1; called with WIDTH+1 so the
  // iteration counter can hold WIDTH itself.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/multdiv_ucore.sv
// rtl/multdiv_ucore.sv - unsigned one-bit-per-cycle shift-add multiplier / restoring divider
// Purpose: iterates on operand magnitudes; signs are handled by the parent.
// Ports:
//   clock_i, reset_i     clock, asynchronous active-low reset
//   load_i               load magnitudes and clear the partial result
//   step_i               perform one iteration
//   is_div_i             1 = divide, 0 = multiply (for load and step)
//   a_mag_i, b_mag_i     unsigned magnitudes of operand a and b
//   hi_next_o, lo_next_o register contents after this cycle's load/step
//                        (multiply: {hi,lo} = product; divide: lo = quotient)
module multdiv_ucore #(
  parameter int WIDTH = 32
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_mag_i,
  input  logic [WIDTH-1:0] b_mag_i,
  output logic [WIDTH-1:0] hi_next_o,
  output logic [WIDTH-1:0] lo_next_o
);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo, div_sub;
  logic             div_ge;

  always_comb begin
    // Multiply: conditionally add the multiplicand into the high half, then
    // shift the whole {carry, hi, lo} right; lo drains the multiplier bits.
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits. The remainder stays below the divisor,
    // so the difference always fits in WIDTH bits.
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, m_q});
    div_sub   = div_shift[WIDTH-1:0] - m_q;
    div_hi    = div_ge ? div_sub : div_shift[WIDTH-1:0];
    div_lo    = {lo_q[WIDTH-2:0], div_ge};

    hi_d = hi_q;
    lo_d = lo_q;
    m_d  = m_q;
    if (load_i) begin
      hi_d = '0;
      lo_d = is_div_i ? a_mag_i : b_mag_i;
      m_d  = is_div_i ? b_mag_i : a_mag_i;
    end else if (step_i) begin
      hi_d = is_div_i ? div_hi : mul_hi;
      lo_d = is_div_i ? div_lo : mul_lo;
    end
  end

  assign hi_next_o = hi_d;
  assign lo_next_o = lo_d;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      hi_q <= '0;
      lo_q <= '0;
      m_q  <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      m_q  <= m_d;
    end
  end

endmodule

// File: rtl/param_multdiv.sv
// rtl/param_multdiv.sv - fixed-latency signed multiply/divide with overflow and divide-by-zero flag
// Purpose: accepts one signed op in IDLE, iterates WIDTH cycles, presents the
//          result with a one-cycle ready pulse.
// Ports:
//   clock, reset              clock, asynchronous active-low reset
//   start_mul, start_div      op requests (ignored when both high or not IDLE)
//   operand_a, operand_b      two's complement operands, sampled on accept
//   result, exception         completed result and overflow/div-by-zero flag
//   ready                     one-cycle pulse when result/exception are new
//   busy                      high while an op is in progress
module param_multdiv
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             ready,
  output logic             busy
);

  localparam int CW = clog2(WIDTH + 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d, bzero_q, bzero_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;

  logic [WIDTH-1:0]   a_mag, b_mag, hi_next, lo_next, quot_s, div_res;
  logic [2*WIDTH-1:0] prod_s;
  logic               mul_exc, div_exc, core_load, core_step, core_div;

  always_comb begin
    a_mag = operand_a[WIDTH-1] ? (~operand_a + WIDTH'(1)) : operand_a;
    b_mag = operand_b[WIDTH-1] ? (~operand_b + WIDTH'(1)) : operand_b;

    // Signed product overflows when its upper half is not the sign extension
    // of the lower half.
    prod_s  = neg_q ? (~{hi_next, lo_next} + (2*WIDTH)'(1)) : {hi_next, lo_next};
    mul_exc = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});

    // A non-negative quotient with its top bit set can only be
    // most-negative / -1; its bit pattern is already the most-negative value.
    quot_s  = neg_q ? (~lo_next + WIDTH'(1)) : lo_next;
    div_res = bzero_q ? '0 : quot_s;
    div_exc = bzero_q | (~neg_q & lo_next[WIDTH-1]);
  end

  assign core_div = (state_q == IDLE) ? start_div : (op_q == OP_DIV);

  multdiv_ucore #(.WIDTH(WIDTH)) u_core (
    .clock_i   (clock),
    .reset_i   (reset),
    .load_i    (core_load),
    .step_i    (core_step),
    .is_div_i  (core_div),
    .a_mag_i   (a_mag),
    .b_mag_i   (b_mag),
    .hi_next_o (hi_next),
    .lo_next_o (lo_next)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    bzero_d   = bzero_q;
    result_d  = result_q;
    exc_d     = exc_q;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_mul ^ start_div) begin
          state_d   = RUN;
          op_d      = start_div ? OP_DIV : OP_MUL;
          cnt_d     = CW'(WIDTH);
          neg_d     = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
          bzero_d   = (operand_b == '0);
          core_load = 1'b1;
        end
      end
      RUN: begin
        core_step = 1'b1;
        cnt_d     = cnt_q - CW'(1);
        // Last iteration: the core's next-state already holds the final value.
        if (cnt_q == CW'(1)) begin
          state_d  = DONE;
          result_d = (op_q == OP_DIV) ? div_res : prod_s[WIDTH-1:0];
          exc_d    = (op_q == OP_DIV) ? div_exc : mul_exc;
        end
      end
      DONE: begin
        state_d = IDLE;
        op_d    = OP_NONE;
      end
      default: begin
        state_d = IDLE;
        op_d    = OP_NONE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_q     <= OP_NONE;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      bzero_q  <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      bzero_q  <= bzero_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign result    = result_q;
  assign exception = exc_q;
  assign ready     = (state_q == DONE);
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/param_multdiv.md
PARAM_MULTDIV -- requirements
Module: param_multdiv

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; legal range 4..64.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset; asserting it (0) clears all state immediately, independent of clock.
REQ-004 start_mul  in  1  request signed multiply of operand_a by operand_b.
REQ-005 start_div  in  1  request signed divide of operand_a by operand_b.
REQ-006 operand_a  in  WIDTH  first operand, two's complement.
REQ-007 operand_b  in  WIDTH  second operand, two's complement.
REQ-008 result  out  WIDTH  product low bits or quotient, two's complement.
REQ-009 exception  out  1  overflow or divide-by-zero flag for the completed operation.
REQ-010 ready  out  1  one-cycle pulse marking result/exception valid.
REQ-011 busy  out  1  high while an operation is in progress.

Function
REQ-012 States IDLE, RUN, DONE; reset enters IDLE.
REQ-013 In IDLE, exactly one of start_mul/start_div high at a rising edge: latch operands and op, load counter with WIDTH, go to RUN, busy=1 from the next cycle.
REQ-014 Both start_mul and start_div high in the same cycle: no operation accepted, remain IDLE.
REQ-015 Starts while busy=1 or during DONE are ignored; latched operands are unaffected.
REQ-016 RUN executes one iteration per cycle (shift-add multiply, restoring divide on magnitudes); counter decrements each cycle; counter reaching 0 moves to DONE.
REQ-017 Latency fixed: ready=1 exactly WIDTH+1 rising edges after the accepting edge, for exactly one cycle (DONE), then IDLE; divide-by-zero keeps the same latency.
REQ-018 busy=1 in RUN and DONE; 0 in IDLE.
REQ-019 A new start is accepted on the edge that leaves DONE only if sampled in IDLE; back-to-back throughput one op per WIDTH+2 cycles.
REQ-020 Multiply: result = low WIDTH bits of full 2*WIDTH signed product; exception=1 when full product is not the sign-extension of those bits.
REQ-021 Divide: quotient truncated toward zero; remainder discarded.
REQ-022 Divide by zero: result=0, exception=1.
REQ-023 Divide most-negative by -1: result=most-negative value, exception=1.
REQ-024 result and exception update only at entry to DONE and hold until the next completion.
REQ-025 Operand inputs are ignored after the accepting edge.

Reset
REQ-026 While reset=0: state IDLE, counter 0, result 0, exception 0, ready 0, busy 0.
REQ-027 Reset asserted mid-operation aborts it; no ready pulse follows for the aborted operation.
REQ-028 First start can be accepted on the first rising edge after reset deasserts.

Structure
REQ-029 Shared package multdiv_pkg holds the op type (OP_NONE, OP_MUL, OP_DIV), state type (IDLE, RUN, DONE) and counter-width function clog2(WIDTH+1).
REQ-030 Sign handling (magnitude conversion, result negation, exception decode) stays in param_multdiv; unsigned iterative datapath is one sub-module, multdiv_ucore.
REQ-031 No multiplier or divider operators inferred; datapath uses add/subtract/shift only.

Verification
REQ-032 WIDTH=32, start_mul, a=7, b=-3 -> ready at edge 33 after accept, result=-21, exception=0.
REQ-033 WIDTH=32, start_mul, a=0x00010000, b=0x00010000 -> result=0, exception=1.
REQ-034 WIDTH=32, start_div, a=-7, b=2 -> result=-3, exception=0; then start_div a=5, b=0 -> result=0, exception=1, same latency.
REQ-035 WIDTH=8, start_div a=-128, b=-1 -> result=-128, exception=1; start_mul a=127, b=2 -> result=-2, exception=1.
REQ-036 WIDTH=32, start_mul accepted, start_div pulsed at cycle 5, both starts together in IDLE -> only first op completes, one ready pulse, no others.
REQ-037 WIDTH=32, reset=0 at cycle 10 of a divide for 1 ns -> busy=0, result=0 immediately, no ready pulse; new start_mul 3*4 afterwards -> result=12.
